// File: rtl/wb_regfile_pkg.sv
// ----------------------------------------------------------------------------
// rv32i_pkg : shared constants and helpers for the RV32I writeback stage.
//   XLEN        data width of registers and result paths
//   REG_ADDR_W  register index width (all 5 bits significant)
//   NREGS       number of architectural registers (x0 hardwired to zero)
//   CNT_W       width of the retired-instruction counter
//   RESULT_*    result-select encodings (2'b11 is reserved and yields zero)
//   select_result() writeback result mux
// ----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam int CNT_W      = 64;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    // Reserved select code returns zero so a corrupted select never leaks data.
    function automatic logic [XLEN-1:0] select_result(
        input logic [1:0]      src,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] mem,
        input logic [XLEN-1:0] pc4
    );
        logic [XLEN-1:0] res;
        case (src)
            RESULT_ALU: res = alu;
            RESULT_MEM: res = mem;
            RESULT_PC4: res = pc4;
            default:    res = {XLEN{1'b0}};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/wb_regfile_if.sv
// ----------------------------------------------------------------------------
// wb_regfile_if : MEM/WB writeback bundle plus decode-stage read ports.
//   master modport : pipeline side (drives MEM/WB fields and read indices)
//   slave  modport : wb_regfile side (returns read data and the WB result)
// Signals: alu_result_w, read_data_w, pc_plus4_w, rd_w, reg_write_w,
//          result_src_w, valid_w, rs1_d, rs2_d -> rd1_d, rd2_d, result_w
// ----------------------------------------------------------------------------
interface wb_regfile_if
    import rv32i_pkg::*;
#(
    parameter int W = XLEN
);

    logic [W-1:0]          alu_result_w;
    logic [W-1:0]          read_data_w;
    logic [W-1:0]          pc_plus4_w;
    logic [REG_ADDR_W-1:0] rd_w;
    logic                  reg_write_w;
    logic [1:0]            result_src_w;
    logic                  valid_w;
    logic [REG_ADDR_W-1:0] rs1_d;
    logic [REG_ADDR_W-1:0] rs2_d;
    logic [W-1:0]          rd1_d;
    logic [W-1:0]          rd2_d;
    logic [W-1:0]          result_w;

    modport master (
        output alu_result_w, read_data_w, pc_plus4_w, rd_w, reg_write_w,
               result_src_w, valid_w, rs1_d, rs2_d,
        input  rd1_d, rd2_d, result_w
    );

    modport slave (
        input  alu_result_w, read_data_w, pc_plus4_w, rd_w, reg_write_w,
               result_src_w, valid_w, rs1_d, rs2_d,
        output rd1_d, rd2_d, result_w
    );

endinterface

// File: rtl/wb_regfile_reg_array_32x32.sv
// ----------------------------------------------------------------------------
// reg_array_32x32 : storage for x1..x31, one write port, two async read ports.
//   clk, rst_n      clock and asynchronous active-low reset (clears x1..x31)
//   we, waddr, wdata  write port; writes to index 0 are dropped
//   raddr1/raddr2   read indices; index 0 always returns zero
//   rdata1/rdata2   combinational read data (old value during a write cycle)
// x0 has no storage element at all.
// ----------------------------------------------------------------------------
module reg_array_32x32
    import rv32i_pkg::*;
#(
    parameter int DW    = XLEN,
    parameter int NR    = NREGS,
    parameter int AW    = REG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] regs_r [1:NR-1];

    // Register storage: async clear, single write port, x0 never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NR; i++) begin
                regs_r[i] <= {DW{1'b0}};
            end
        end else if (we && (waddr != {AW{1'b0}})) begin
            regs_r[waddr] <= wdata;
        end
    end

    // Read ports: index 0 decodes to constant zero.
    always_comb begin
        rdata1 = {DW{1'b0}};
        rdata2 = {DW{1'b0}};
        if (raddr1 != {AW{1'b0}}) begin
            rdata1 = regs_r[raddr1];
        end else begin
            rdata1 = {DW{1'b0}};
        end
        if (raddr2 != {AW{1'b0}}) begin
            rdata2 = regs_r[raddr2];
        end else begin
            rdata2 = {DW{1'b0}};
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile : RV32I writeback stage + integer register file.
//   clk, rst_n    pipeline clock, asynchronous active-low reset
//   bus (slave)   MEM/WB fields in; rd1_d/rd2_d/result_w out
//   retire_count  count of retired (valid) instructions, wraps silently
// Optional build macro WB_REGFILE_BYPASS_EN: a read of the register being
// written this cycle returns result_w combinationally (never for x0).
// Without it the old value is returned and the hazard unit must stall.
// ----------------------------------------------------------------------------
module wb_regfile #(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int NREGS = rv32i_pkg::NREGS,
    parameter int CNT_W = rv32i_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_regfile_if.slave      bus,
    output logic [CNT_W-1:0] retire_count
);
    import rv32i_pkg::*;

    logic [XLEN-1:0]  result_s;
    logic             wr_en_s;
    logic [XLEN-1:0]  arr_rd1_s;
    logic [XLEN-1:0]  arr_rd2_s;
    logic [XLEN-1:0]  rd1_s;
    logic [XLEN-1:0]  rd2_s;
    logic [CNT_W-1:0] retire_cnt_r;

    // Writeback result select and commit qualification (bubbles never write).
    always_comb begin
        result_s = select_result(bus.result_src_w, bus.alu_result_w,
                                 bus.read_data_w, bus.pc_plus4_w);
        wr_en_s  = bus.reg_write_w && bus.valid_w &&
                   (bus.rd_w != {REG_ADDR_W{1'b0}});
    end

    reg_array_32x32 #(
        .DW (XLEN),
        .NR (NREGS),
        .AW (REG_ADDR_W)
    ) u_reg_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_en_s),
        .waddr  (bus.rd_w),
        .wdata  (result_s),
        .raddr1 (bus.rs1_d),
        .raddr2 (bus.rs2_d),
        .rdata1 (arr_rd1_s),
        .rdata2 (arr_rd2_s)
    );

    // Read port data, optionally forwarding the in-flight write (wr_en_s excludes x0).
    always_comb begin
        rd1_s = arr_rd1_s;
        rd2_s = arr_rd2_s;
`ifdef WB_REGFILE_BYPASS_EN
        if (wr_en_s && (bus.rs1_d == bus.rd_w)) begin
            rd1_s = result_s;
        end else begin
            rd1_s = arr_rd1_s;
        end
        if (wr_en_s && (bus.rs2_d == bus.rd_w)) begin
            rd2_s = result_s;
        end else begin
            rd2_s = arr_rd2_s;
        end
`else
        rd1_s = arr_rd1_s;
        rd2_s = arr_rd2_s;
`endif
    end

    // Retired-instruction counter: every valid slot retires, wraps without a flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_r <= {CNT_W{1'b0}};
        end else if (bus.valid_w) begin
            retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.rd1_d    = rd1_s;
    assign bus.rd2_d    = rd2_s;
    assign bus.result_w = result_s;
    assign retire_count = retire_cnt_r;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;
    import rv32i_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] cnt64;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    wb_regfile_if #(.W(32)) bus  ();
    wb_regfile_if #(.W(32)) bus4 ();

    // Narrow-counter copy shares every input so its wrap can be reached quickly.
    assign bus4.alu_result_w = bus.alu_result_w;
    assign bus4.read_data_w  = bus.read_data_w;
    assign bus4.pc_plus4_w   = bus.pc_plus4_w;
    assign bus4.rd_w         = bus.rd_w;
    assign bus4.reg_write_w  = bus.reg_write_w;
    assign bus4.result_src_w = bus.result_src_w;
    assign bus4.valid_w      = bus.valid_w;
    assign bus4.rs1_d        = bus.rs1_d;
    assign bus4.rs2_d        = bus.rs2_d;

    wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .retire_count(cnt64));

    wb_regfile #(.XLEN(32), .NREGS(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave), .retire_count(cnt4));

    // Reference model state
    logic [31:0] mdl [32];
    logic [63:0] m_cnt;
    int          m_cnt4;
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic logic [31:0] spec_result();
        case (bus.result_src_w)
            2'd0:    return bus.alu_result_w;
            2'd1:    return bus.read_data_w;
            2'd2:    return bus.pc_plus4_w;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] spec_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (bus.valid_w && bus.reg_write_w && (bus.rd_w == idx)) return spec_result();
`endif
        return mdl[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        m_cnt  = 64'h0;
        m_cnt4 = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge; the model retires the slot presented before the edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            if (bus.valid_w) begin
                m_cnt  = m_cnt + 64'd1;
                m_cnt4 = (m_cnt4 + 1) % 16;
                if (bus.reg_write_w && bus.rd_w != 5'd0) mdl[bus.rd_w] = spec_result();
            end
        end else begin
            model_clear();
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input logic regw, input logic valid);
        bus.rd_w = rd; bus.result_src_w = src;
        bus.alu_result_w = alu; bus.read_data_w = mem; bus.pc_plus4_w = pc4;
        bus.reg_write_w = regw; bus.valid_w = valid;
    endtask

    task automatic check_ports(input string tag);
        #1;
        chk({tag, ".result"}, {32'h0, bus.result_w}, {32'h0, spec_result()});
        chk({tag, ".rd1"},    {32'h0, bus.rd1_d},    {32'h0, spec_read(bus.rs1_d)});
        chk({tag, ".rd2"},    {32'h0, bus.rd2_d},    {32'h0, spec_read(bus.rs2_d)});
    endtask

    task automatic check_cnt(input string tag);
        chk({tag, ".cnt64"}, cnt64, m_cnt);
        chk({tag, ".cnt4"},  {60'h0, cnt4}, 64'(m_cnt4));
    endtask

    // Read a register through port 1 with a bubble in WB (no bypass possible).
    task automatic read_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        drive(5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.rs1_d = idx;
        #1;
        chk(tag, {32'h0, bus.rd1_d}, {32'h0, exp});
    endtask

    initial begin
        logic [63:0] c0;
        // ---------------- reset state ----------------
        rst_n = 1'b0;
        model_clear();
        drive(5'd3, 2'd0, 32'h1234_5678, 32'h0, 32'h0, 1'b1, 1'b1);
        bus.rs1_d = 5'd0; bus.rs2_d = 5'd0;
        for (int i = 0; i < 32; i++) begin
            bus.rs1_d = 5'(i); bus.rs2_d = 5'(31 - i);
            #1;
            chk("reset.rd1", {32'h0, bus.rd1_d}, 64'h0);
            chk("reset.rd2", {32'h0, bus.rd2_d}, 64'h0);
        end
        cycle(); cycle();
        check_cnt("reset_hold");
        bus.rs1_d = 5'd3; #1;
        chk("reset_hold.x3", {32'h0, bus.rd1_d}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- result select ----------------
        bus.rs2_d = 5'd0;
        drive(5'd5, 2'd0, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1); bus.rs1_d = 5'd1; check_ports("sel_alu"); cycle();
        drive(5'd6, 2'd1, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1); check_ports("sel_mem"); cycle();
        drive(5'd7, 2'd2, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1); check_ports("sel_pc4"); cycle();
        drive(5'd8, 2'd3, 32'h11, 32'h22, 32'h33, 1'b1, 1'b1); check_ports("sel_rsv"); cycle();
        read_reg("x5", 5'd5, 32'h11);
        read_reg("x6", 5'd6, 32'h22);
        read_reg("x7", 5'd7, 32'h33);
        read_reg("x8", 5'd8, 32'h0);
        check_cnt("after_sel");

        // ---------------- x0 and bubble ----------------
        drive(5'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b1, 1'b1);
        bus.rs1_d = 5'd0; #1;
        chk("x0_pre", {32'h0, bus.rd1_d}, 64'h0);
        cycle();
        read_reg("x0_post", 5'd0, 32'h0);
        c0 = m_cnt;
        drive(5'd9, 2'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 1'b1, 1'b0); cycle();
        read_reg("bubble_x9", 5'd9, 32'h0);
        chk("bubble_cnt", cnt64, c0);

        // ---------------- same-cycle read ----------------
        drive(5'd10, 2'd0, 32'h1, 32'h0, 32'h0, 1'b1, 1'b1); cycle();
        drive(5'd10, 2'd0, 32'hA5A5_A5A5, 32'h0, 32'h0, 1'b1, 1'b1);
        bus.rs1_d = 5'd10; bus.rs2_d = 5'd10; #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("same_cycle", {32'h0, bus.rd1_d}, 64'hA5A5_A5A5);
`else
        chk("same_cycle", {32'h0, bus.rd1_d}, 64'h1);
`endif
        check_ports("same_cycle_model");
        cycle();
        read_reg("next_cycle", 5'd10, 32'hA5A5_A5A5);

        // ---------------- counter: 10 valid (3 no-write) + 4 bubbles ----------------
        c0 = m_cnt;
        for (int i = 0; i < 14; i++) begin
            logic v, w;
            v = !(i == 1 || i == 4 || i == 8 || i == 12);
            w = !(i == 2 || i == 6 || i == 10);
            drive(5'(12 + i), 2'd0, $urandom, $urandom, $urandom, w, v);
            bus.rs1_d = 5'($urandom_range(0, 31)); bus.rs2_d = 5'($urandom_range(0, 31));
            check_ports("cnt_mix");
            cycle();
        end
        chk("cnt_plus10", cnt64, c0 + 64'd10);
        check_cnt("cnt_mix");

        // ---------------- port independence ----------------
        drive(5'd31, 2'd0, 32'h7FFF_FFFF, 32'h0, 32'h0, 1'b1, 1'b1); cycle();
        drive(5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        bus.rs1_d = 5'd31; bus.rs2_d = 5'd31; #1;
        chk("dual31.rd1", {32'h0, bus.rd1_d}, 64'h7FFF_FFFF);
        chk("dual31.rd2", {32'h0, bus.rd2_d}, 64'h7FFF_FFFF);
        bus.rs2_d = 5'd0; #1;
        chk("split.rd1", {32'h0, bus.rd1_d}, 64'h7FFF_FFFF);
        chk("split.rd2", {32'h0, bus.rd2_d}, 64'h0);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 300; i++) begin
            drive(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
            bus.rs1_d = ($urandom_range(0, 3) == 0) ? bus.rd_w : 5'($urandom_range(0, 31));
            bus.rs2_d = ($urandom_range(0, 3) == 0) ? bus.rd_w : 5'($urandom_range(0, 31));
            check_ports("rand");
            cycle();
            check_cnt("rand");
        end

        // ---------------- asynchronous reset mid-run ----------------
        drive(5'd31, 2'd0, 32'h5555_AAAA, 32'h0, 32'h0, 1'b1, 1'b1);
        bus.rs1_d = 5'd5; bus.rs2_d = 5'd10;
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        model_clear();
        chk("async_rst.rd1", {32'h0, bus.rd1_d}, 64'h0);
        chk("async_rst.rd2", {32'h0, bus.rd2_d}, 64'h0);
        check_cnt("async_rst");
        cycle();
        check_cnt("rst_overrides");
        read_reg("rst_x31", 5'd31, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- narrow counter wrap from all-ones ----------------
        for (int i = 0; i < 15; i++) begin
            drive(5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
            cycle();
        end
        chk("cnt4_all_ones", {60'h0, cnt4}, 64'hF);
        cycle();
        chk("cnt4_wrap", {60'h0, cnt4}, 64'h0);
        check_cnt("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Writeback stage plus integer register file for the RV32I 5-stage pipeline. It consumes the MEM/WB pipeline register outputs and selects the writeback result. It commits that result into the 32x32 architectural register file and serves the two decode-stage read ports. It also keeps a 64-bit retired-instruction counter and exports the writeback result for EX-stage forwarding.

Parameters:
XLEN, 32, data width of registers and result paths
NREGS, 32, number of architectural registers; x0 is hardwired to zero
CNT_W, 64, width of retired-instruction counter

Ports:
Clk  input  1  pipeline clock; all state updates on rising edge
Rst_n  input  1  asynchronous active-low reset
alu_result_w  input  XLEN  ALU result from MEM/WB register
read_data_w  input  XLEN  load data from MEM/WB register
pc_plus4_w  input  XLEN  link address from MEM/WB register
rd_w  input  5  destination register index (all 5 bits significant)
reg_write_w  input  1  register write enable for the WB instruction
result_src_w  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 reserved
valid_w  input  1  WB slot holds a real (non-bubble) instruction
rs1_d  input  5  decode read port 1 index
rs2_d  input  5  decode read port 2 index
rd1_d  output  XLEN  read port 1 data
rd2_d  output  XLEN  read port 2 data
result_w  output  XLEN  selected writeback result, to the forwarding mux
retire_count  output  CNT_W  count of retired instructions

Behaviour:
- Reset is asynchronous and active-low. Clk is a single clock. While Rst_n=0, all registers x1..x31 are 0 and retire_count is 0. rd1_d and rd2_d therefore read 0.
- Result select is combinational: result_w = alu_result_w, read_data_w, or pc_plus4_w for result_src_w 00, 01, or 10. result_src_w=11 yields 0.
- Write: on a rising Clk edge with Rst_n=1, reg_write_w=1, valid_w=1 and rd_w!=0, x[rd_w] <= result_w. Writes to x0 are discarded, and x0 is never storage.
- Reads are combinational. Index 0 returns 0.
- Without the optional feature, a read of the register being written in the same cycle returns the old value. The new value appears the cycle after the edge.
- retire_count increments by 1 on each rising edge where valid_w=1. This is independent of reg_write_w, so stores and branches also retire. It wraps from all-ones to 0 with no flag.
- Reset mid-operation: assertion of Rst_n overrides any pending write or increment in that cycle. Deassertion takes effect at the first edge after Rst_n=1 is stable.
- Bubble (valid_w=0): no write and no count, even if reg_write_w=1.
- Latency: write-to-read is 1 cycle without the optional feature, 0 cycles with it.

Optional Feature:
Macro WB_REGFILE_BYPASS_EN.
- Defined: a read port whose index equals rd_w returns result_w combinationally, provided reg_write_w=1, valid_w=1 and rd_w!=0. Bypass never applies to index 0. This removes the WB-to-ID hazard.
- Undefined: no bypass, as described under Behaviour. The hazard unit must then stall one cycle.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN and REG_ADDR_W=5
  - result-select constants RESULT_ALU=2'b00, RESULT_MEM=2'b01, RESULT_PC4=2'b10
  - CNT_W
- One natural sub-module, reg_array_32x32: storage for x1..x31 with async-low reset, one write port and two read ports, with x0 zero logic. The result mux, bypass and counter stay in wb_regfile.

Test Plan:
- Reset: hold Rst_n=0, read all 32 indices -> every rd1_d and rd2_d is 0, retire_count=0. Assert Rst_n mid-run -> all clear immediately, without waiting for a clock edge.
- Result select: alu_result_w=0x11, read_data_w=0x22, pc_plus4_w=0x33. Write x5 with src 00, x6 with src 01, x7 with src 10 -> reads return 0x11, 0x22, 0x33. Src 11 to x8 -> x8 reads 0.
- x0 and bubble: write 0xDEADBEEF to rd_w=0 -> rs1_d=0 reads 0. Write x9 with valid_w=0 -> x9 unchanged and retire_count unchanged.
- Same-cycle read: write 0xA5A5A5A5 to x10 while rs1_d=10, x10 previously 0x1 -> rd1_d=0x1 without the macro, 0xA5A5A5A5 with WB_REGFILE_BYPASS_EN. Next cycle both read 0xA5A5A5A5.
- Counter: 10 valid cycles, including 3 with reg_write_w=0, interleaved with 4 bubbles -> retire_count=10. Force the counter to all-ones, then 1 valid cycle -> retire_count=0.
- Port independence: rs1_d=rs2_d=31 after writing 0x7FFFFFFF -> both ports read 0x7FFFFFFF. rs1_d=31, rs2_d=0 -> rd2_d=0.
